// File: rtl/led_matrix_scan.sv
// Row-scanned 16x16 LED matrix driver: double-buffered frame, serial column shift into a
// 74HC595 chain, latch, then hold the row lit while a 4-to-16 decoder selects it.
module led_matrix_scan #(
  parameter int CLK_DIV  = 4,
  parameter int ROW_HOLD = 2000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] frame_in,
  input  logic         frame_valid,
  output logic         ser,
  output logic         srclk,
  output logic         rclk,
  output logic [3:0]   row_sel,
  output logic         oe_n,
  output logic         frame_done
);

  // One shared counter covers a full srclk period, the latch pulse and the row hold.
  localparam int CNT_TOP = (2 * CLK_DIV > ROW_HOLD) ? 2 * CLK_DIV : ROW_HOLD;
  localparam int CW      = $clog2(CNT_TOP);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HI_START   = CW'(CLK_DIV);
  localparam logic [CW-1:0] LATCH_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(ROW_HOLD - 1);

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH, HOLD} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [3:0]     bit_reg, bit_next;
  logic [3:0]     row_reg, row_next;
  logic [15:0]    sh_reg, sh_next;
  logic [255:0]   pend_reg, disp_reg;
  logic           pend_flag_reg;
  logic           swap;
  logic [15:0]    pend_rows [16];
  logic [15:0]    disp_rows [16];

  logic           ser_next, srclk_next, rclk_next, oe_n_next, frame_done_next;
  logic [3:0]     row_sel_next;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rows
      assign pend_rows[gi] = pend_reg[255 - 16 * gi -: 16];
      assign disp_rows[gi] = disp_reg[255 - 16 * gi -: 16];
    end
  endgenerate

  // Frames swap in only at the start of row 0, so a displayed frame never tears.
  assign swap = (state_reg == LOAD) && (row_reg == 4'd0) && pend_flag_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg      <= '0;
      disp_reg      <= '0;
      pend_flag_reg <= 1'b0;
    end else begin
      if (frame_valid) pend_reg <= frame_in;
      if (swap) disp_reg <= pend_reg;
      if (frame_valid) pend_flag_reg <= 1'b1;
      else if (swap)   pend_flag_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
      bit_reg   <= 4'd15;
      row_reg   <= 4'd0;
      sh_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      row_reg   <= row_next;
      sh_reg    <= sh_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    row_next   = row_reg;
    sh_next    = sh_reg;
    case (state_reg)
      LOAD: begin
        state_next = SHIFT;
        cnt_next   = '0;
        bit_next   = 4'd15;
        sh_next    = swap ? pend_rows[row_reg] : disp_rows[row_reg];
      end
      SHIFT: begin
        if (cnt_reg == SHIFT_LAST) begin
          cnt_next = '0;
          if (bit_reg == 4'd0) state_next = LATCH;
          else                 bit_next   = bit_reg - 4'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LATCH: begin
        if (cnt_reg == LATCH_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = LOAD;
          cnt_next   = '0;
          row_next   = row_reg + 4'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    ser_next        = ser;
    srclk_next      = 1'b0;
    rclk_next       = 1'b0;
    row_sel_next    = row_sel;
    oe_n_next       = 1'b0;
    frame_done_next = 1'b0;
    case (state_next)
      SHIFT: begin
        ser_next   = sh_next[bit_next];
        srclk_next = (cnt_next >= HI_START);
      end
      LATCH: begin
        rclk_next    = 1'b1;
        oe_n_next    = 1'b1;
        row_sel_next = row_next;
      end
      HOLD: frame_done_next = (cnt_next == HOLD_LAST) && (row_next == 4'd15);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser        <= 1'b0;
      srclk      <= 1'b0;
      rclk       <= 1'b0;
      row_sel    <= 4'd0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      ser        <= ser_next;
      srclk      <= srclk_next;
      rclk       <= rclk_next;
      row_sel    <= row_sel_next;
      oe_n       <= oe_n_next;
      frame_done <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: a fast instance checked row by row against a frame-level model,
// plus a default-parameter instance checked for scan timing.
module tb_led_matrix_scan;

  localparam int CD     = 1;
  localparam int RH     = 4;
  localparam int ROWP   = 1 + 33 * CD + RH;
  localparam int FRM    = 16 * ROWP;
  localparam int CD_D   = 4;
  localparam int ROWP_D = 1 + 33 * CD_D + 2000;

  logic         clk = 1'b0;
  logic         rst_n, rst_n_d;
  logic [255:0] frame_in, frame_in_d;
  logic         frame_valid, frame_valid_d;
  logic         s_ser, s_srclk, s_rclk, s_oe_n, s_fd;
  logic [3:0]   s_row;
  logic         d_ser, d_srclk, d_rclk, d_oe_n, d_fd;
  logic [3:0]   d_row;

  always #5 clk = ~clk;

  led_matrix_scan #(.CLK_DIV(CD), .ROW_HOLD(RH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
    .ser(s_ser), .srclk(s_srclk), .rclk(s_rclk), .row_sel(s_row), .oe_n(s_oe_n), .frame_done(s_fd)
  );

  led_matrix_scan dut_d (
    .clk(clk), .rst_n(rst_n_d), .frame_in(frame_in_d), .frame_valid(frame_valid_d),
    .ser(d_ser), .srclk(d_srclk), .rclk(d_rclk), .row_sel(d_row), .oe_n(d_oe_n), .frame_done(d_fd)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: cycle n of a scan is the cycle after the n-th post-reset edge.
  typedef struct { int row; logic [15:0] word; } exp_t;
  exp_t        expq[$];
  logic [15:0] m_pend [16];
  logic [15:0] m_disp [16];
  bit          m_flag;
  int          cyc = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin m_pend[i] = '0; m_disp[i] = '0; end
      m_flag = 0;
      cyc = 0;
      expq.delete();
    end else begin
      if (cyc % ROWP == 0) begin
        int row;
        row = (cyc / ROWP) % 16;
        if (row == 0 && m_flag) begin
          for (int i = 0; i < 16; i++) m_disp[i] = m_pend[i];
          m_flag = 0;
        end
        expq.push_back('{row, m_disp[row]});
      end
      if (frame_valid) begin
        for (int i = 0; i < 16; i++) m_pend[i] = frame_in[255 - 16 * i -: 16];
        m_flag = 1;
      end
      cyc++;
    end
  end

  // Fast-instance monitor: captures shifted words and compares each latched row.
  logic        p_srclk, p_rclk, p_ser;
  logic [3:0]  p_row;
  logic [15:0] cap;
  int          nbits, stable, rows_seen = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      p_srclk = 0; p_rclk = 0; p_ser = 0; p_row = 0; cap = 0; nbits = 0; stable = 1;
    end else begin
      int ph;
      bit exp_rclk, exp_fd;
      ph = cyc % ROWP;
      exp_rclk = (ph >= 1 + 32 * CD) && (ph <= 33 * CD);
      exp_fd = (cyc % FRM == FRM - 1);
      if (s_rclk || exp_rclk) check("rclk_window", s_rclk, exp_rclk);
      if (s_fd || exp_fd) check("frame_done", s_fd, exp_fd);
      if (s_rclk && s_srclk) check("rclk_srclk_overlap", 1, 0);
      if (s_row != p_row) check("oe_n_on_row_change", s_oe_n, 1);
      stable = (s_ser == p_ser) ? stable + 1 : 1;
      if (s_srclk && !p_srclk) begin
        check("ser_setup", stable >= CD + 1, 1);
        cap = {cap[14:0], s_ser};
        nbits++;
      end
      if (s_rclk && !p_rclk) begin
        if (expq.size() == 0) check("row_expected", 0, 1);
        else begin
          exp_t e;
          e = expq.pop_front();
          check("row_bits", nbits, 16);
          check("row_word", cap, e.word);
          check("row_sel", s_row, e.row);
          rows_seen++;
        end
        nbits = 0;
      end
      p_srclk = s_srclk; p_rclk = s_rclk; p_ser = s_ser; p_row = s_row;
    end
  end

  // Default-instance monitor: scan timing only.
  int  cyc_d = 0, last_rise = 0, rise_cnt = 0, last_row_t = 0;
  bit  done_d = 0;
  logic q_srclk = 0, q_rclk = 0;
  logic [3:0] q_row = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n_d) begin
      cyc_d++;
      if (d_rclk && d_srclk) check("d_rclk_srclk_overlap", 1, 0);
      if (d_srclk && !q_srclk) begin
        if (rise_cnt > 0) check("d_srclk_period", cyc_d - last_rise, 2 * CD_D);
        last_rise = cyc_d;
        rise_cnt++;
      end
      if (d_rclk && !q_rclk) begin
        check("d_srclk_per_row", rise_cnt, 16);
        rise_cnt = 0;
      end
      if (d_row != q_row) begin
        check("d_oe_n_on_row_change", d_oe_n, 1);
        if (last_row_t > 0) check("d_row_period", cyc_d - last_row_t, ROWP_D);
        last_row_t = cyc_d;
      end
      if (d_fd && !done_d) begin
        check("d_frame_done_time", cyc_d, 16 * ROWP_D - 1);
        done_d = 1;
      end
      q_srclk = d_srclk; q_rclk = d_rclk; q_row = d_row;
    end
  end

  task automatic wait_mod(input int target);
    for (int k = 0; k < 2 * FRM && (cyc % FRM) != target; k++) @(negedge clk);
    check("wait_mod_reached", cyc % FRM, target);
  endtask

  task automatic pulse_now(input logic [255:0] d);
    frame_in = d;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  function automatic logic [255:0] rnd_frame();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32 * i +: 32] = $urandom;
    return f;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ser"}, s_ser, 0);
    check({tag, "_srclk"}, s_srclk, 0);
    check({tag, "_rclk"}, s_rclk, 0);
    check({tag, "_row_sel"}, s_row, 0);
    check({tag, "_oe_n"}, s_oe_n, 1);
    check({tag, "_frame_done"}, s_fd, 0);
  endtask

  initial begin
    rst_n = 0; rst_n_d = 0;
    frame_in = '0; frame_valid = 0; frame_in_d = '0; frame_valid_d = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_d_oe_n", d_oe_n, 1);
    #2; rst_n = 1; rst_n_d = 1;

    // Single-pixel-pair frame in row 0, then let it scan twice.
    wait_mod(5);
    pulse_now({16'h8001, 240'b0});
    repeat (2 * FRM) @(negedge clk);

    // Two updates mid-frame: only the last one appears, and only from the next row 0.
    wait_mod(5 * ROWP + 10);
    pulse_now(rnd_frame());
    wait_mod(9 * ROWP + 10);
    pulse_now(rnd_frame());

    // Update on the exact row-0 load cycle while another frame is already pending.
    wait_mod(300);
    pulse_now(rnd_frame());
    wait_mod(0);
    pulse_now(rnd_frame());
    repeat (2 * FRM) @(negedge clk);

    // Random updates, occasionally landing on a frame boundary.
    for (int k = 0; k < 4 * FRM; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0 || ((cyc % FRM) == 0 && $urandom_range(0, 1) == 1))
        pulse_now(rnd_frame());
    end

    // Asynchronous reset in the middle of row 7's shift.
    wait_mod(7 * ROWP + 12);
    check("pre_reset_row_sel", s_row, 6);
    #2; rst_n = 0;
    #1; check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    #2; rst_n = 1;
    repeat (2 * FRM + 40) @(negedge clk);

    check("rows_checked_enough", rows_seen >= 150, 1);
    for (int k = 0; k < 16 * ROWP_D + 200 && !done_d; k++) @(negedge clk);
    check("d_frame_done_seen", done_d, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
